// File: rtl/ascii2bin_parser.sv
// ascii2bin_parser: turns ASCII hex tokens ("1a2F\r") into 16-bit words.
// Ports: I_CLK, I_RSTF (async, active-low) | I_CHAR/I_CHAR_VALID/O_CHAR_READY
//        char input handshake | O_BIN/O_BIN_VALID/I_BIN_READY word output
//        handshake | O_DIGITS token length | O_ERR pulse, O_ERR_CNT (saturating).
module ascii2bin_parser (
    input  logic        I_CLK,
    input  logic        I_RSTF,
    input  logic [7:0]  I_CHAR,
    input  logic        I_CHAR_VALID,
    output logic        O_CHAR_READY,
    output logic [15:0] O_BIN,
    output logic        O_BIN_VALID,
    input  logic        I_BIN_READY,
    output logic [2:0]  O_DIGITS,
    output logic        O_ERR,
    output logic [7:0]  O_ERR_CNT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [15:0] acc, acc_nx;
    logic [15:0] bin, bin_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        err, err_nx;
    logic [7:0]  err_cnt;
    logic        is_dig, is_delim;
    logic [3:0]  dig;
    logic        accept;

    always_comb begin
        is_dig   = 1'b0;
        is_delim = 1'b0;
        dig      = 4'h0;
        unique case (1'b1)
            (I_CHAR >= 8'h30 && I_CHAR <= 8'h39): begin
                is_dig = 1'b1;
                dig    = I_CHAR[3:0];
            end
            // 'A'-'F' and 'a'-'f' share low nibbles 1..6
            ((I_CHAR >= 8'h41 && I_CHAR <= 8'h46) ||
             (I_CHAR >= 8'h61 && I_CHAR <= 8'h66)): begin
                is_dig = 1'b1;
                dig    = I_CHAR[3:0] + 4'd9;
            end
            (I_CHAR == 8'h0D || I_CHAR == 8'h0A ||
             I_CHAR == 8'h20 || I_CHAR == 8'h2C): begin
                is_delim = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = I_CHAR_VALID && (state != HOLD);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        bin_nx   = bin;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (is_dig) begin
                        acc_nx   = {12'h000, dig};
                        cnt_nx   = 3'd1;
                        state_nx = ACCUM;
                    end else if (!is_delim) begin
                        err_nx   = 1'b1;
                        cnt_nx   = 3'd0;
                        state_nx = DISCARD;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (is_dig) begin
                        if (cnt == 3'd4) begin
                            err_nx   = 1'b1;
                            cnt_nx   = 3'd0;
                            state_nx = DISCARD;
                        end else begin
                            acc_nx = {acc[11:0], dig};
                            cnt_nx = cnt + 3'd1;
                        end
                    end else if (is_delim) begin
                        bin_nx   = acc;
                        state_nx = HOLD;
                    end else begin
                        err_nx   = 1'b1;
                        cnt_nx   = 3'd0;
                        state_nx = DISCARD;
                    end
                end
            end
            HOLD: begin
                if (I_BIN_READY) begin
                    cnt_nx   = 3'd0;
                    state_nx = IDLE;
                end
            end
            DISCARD: begin
                // digits are dropped quietly; each stray invalid char still counts
                if (accept) begin
                    if (is_delim) begin
                        state_nx = IDLE;
                    end else if (!is_dig) begin
                        err_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            state <= IDLE;
            acc   <= 16'h0000;
            bin   <= 16'h0000;
            cnt   <= 3'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            bin   <= bin_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            err_cnt <= 8'd0;
        end else if (err_nx && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign O_CHAR_READY = (state != HOLD);
    assign O_BIN_VALID  = (state == HOLD);
    assign O_BIN        = bin;
    assign O_DIGITS     = cnt;
    assign O_ERR        = err;
    assign O_ERR_CNT    = err_cnt;

endmodule

// File: tb/tb_ascii2bin_parser.sv
// tb_ascii2bin_parser: directed stimulus for ascii2bin_parser, checked
// per cycle against a token-level model plus literal expectations.
module tb_ascii2bin_parser;

    logic        I_CLK = 1'b0;
    logic        I_RSTF;
    logic [7:0]  I_CHAR;
    logic        I_CHAR_VALID;
    logic        O_CHAR_READY;
    logic [15:0] O_BIN;
    logic        O_BIN_VALID;
    logic        I_BIN_READY;
    logic [2:0]  O_DIGITS;
    logic        O_ERR;
    logic [7:0]  O_ERR_CNT;

    always #5 I_CLK = ~I_CLK;

    ascii2bin_parser dut (
        .I_CLK        (I_CLK),
        .I_RSTF       (I_RSTF),
        .I_CHAR       (I_CHAR),
        .I_CHAR_VALID (I_CHAR_VALID),
        .O_CHAR_READY (O_CHAR_READY),
        .O_BIN        (O_BIN),
        .O_BIN_VALID  (O_BIN_VALID),
        .I_BIN_READY  (I_BIN_READY),
        .O_DIGITS     (O_DIGITS),
        .O_ERR        (O_ERR),
        .O_ERR_CNT    (O_ERR_CNT)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    // token-level model: pending digit text, bad-token flag, held word
    logic [7:0]  tok[$];
    bit          m_bad, m_hold, m_err;
    logic [15:0] m_bin;
    int          m_err_cnt;

    logic [15:0] got_bin[$];
    int          got_dig[$];
    int          err_cycles, hold_cycles, cyc_no;
    bit          prev_valid;

    function automatic int hexval(logic [7:0] c);
        string      h = "0123456789abcdef";
        logic [7:0] l = c;
        if (c >= 8'h41 && c <= 8'h5A) l = c + 8'd32;
        for (int i = 0; i < 16; i++)
            if (h[i] == l) return i;
        return -1;
    endfunction

    function automatic bit is_delim(logic [7:0] c);
        string d = " ,\r\n";
        for (int i = 0; i < d.len(); i++)
            if (d[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] parse_tok();
        int v = 0;
        foreach (tok[i]) v = v * 16 + hexval(tok[i]);
        return 16'(v);
    endfunction

    task automatic model_reset();
        tok.delete();
        m_bad     = 0;
        m_hold    = 0;
        m_err     = 0;
        m_bin     = 16'h0000;
        m_err_cnt = 0;
    endtask

    task automatic model_step();
        int v;
        m_err = 0;
        if (m_hold) begin
            if (I_BIN_READY) begin
                m_hold = 0;
                tok.delete();
            end
        end else if (I_CHAR_VALID) begin
            v = hexval(I_CHAR);
            if (m_bad) begin
                if (is_delim(I_CHAR)) m_bad = 0;
                else if (v < 0) m_err = 1;
            end else if (v >= 0) begin
                if (tok.size() == 4) begin
                    m_err = 1;
                    m_bad = 1;
                    tok.delete();
                end else begin
                    tok.push_back(I_CHAR);
                end
            end else if (is_delim(I_CHAR)) begin
                if (tok.size() > 0) begin
                    m_bin  = parse_tok();
                    m_hold = 1;
                end
            end else begin
                m_err = 1;
                m_bad = 1;
                tok.delete();
            end
        end
        if (m_err && m_err_cnt < 255) m_err_cnt++;
    endtask

    // single per-cycle compare process, sampling at the falling edge
    initial begin
        logic [29:0] exp_v, act_v;
        forever begin
            @(negedge I_CLK);
            cyc_no++;
            if (chk_en) begin
                exp_v = {~m_hold, m_hold, m_bin, 3'(tok.size()),
                         m_err, 8'(m_err_cnt)};
                act_v = {O_CHAR_READY, O_BIN_VALID, O_BIN, O_DIGITS,
                         O_ERR, O_ERR_CNT};
                n_total++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL cycle %0d rdy/vld/bin/dig/err/cnt: got %b/%b/%h/%0d/%b/%0d expected %b/%b/%h/%0d/%b/%0d",
                    cyc_no, act_v[29], act_v[28], act_v[27:12], act_v[11:9],
                    act_v[8], act_v[7:0], exp_v[29], exp_v[28], exp_v[27:12],
                    exp_v[11:9], exp_v[8], exp_v[7:0]);
                if (O_BIN_VALID && !prev_valid) begin
                    got_bin.push_back(O_BIN);
                    got_dig.push_back(int'(O_DIGITS));
                end
                prev_valid = O_BIN_VALID;
                if (O_ERR) err_cycles++;
                if (O_BIN_VALID && !O_CHAR_READY) hold_cycles++;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int bin_at(int i);
        if (i < got_bin.size()) return int'(got_bin[i]);
        return -1;
    endfunction

    function automatic int dig_at(int i);
        if (i < got_dig.size()) return got_dig[i];
        return -1;
    endfunction

    task automatic clear_log();
        got_bin.delete();
        got_dig.delete();
        err_cycles  = 0;
        hold_cycles = 0;
    endtask

    task automatic cyc(bit v, logic [7:0] c, bit r);
        @(negedge I_CLK);
        I_CHAR_VALID = v;
        I_CHAR       = c;
        I_BIN_READY  = r;
        @(posedge I_CLK);
        model_step();
    endtask

    task automatic send(string s, bit r);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], r);
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset(int n);
        @(negedge I_CLK);
        #2;
        I_RSTF       = 1'b0;
        I_CHAR_VALID = 1'b0;
        model_reset();
        repeat (n) @(negedge I_CLK);
        I_RSTF = 1'b1;
    endtask

    initial begin
        I_RSTF       = 1'b0;
        I_CHAR       = 8'h00;
        I_CHAR_VALID = 1'b0;
        I_BIN_READY  = 1'b1;
        model_reset();
        clear_log();
        prev_valid = 0;
        cyc_no     = 0;
        chk_en     = 1;
        repeat (2) @(negedge I_CLK);
        I_RSTF = 1'b1;
        chk("rst_ready",  int'(O_CHAR_READY), 1);
        chk("rst_valid",  int'(O_BIN_VALID), 0);
        chk("rst_bin",    int'(O_BIN), 0);
        chk("rst_digits", int'(O_DIGITS), 0);
        chk("rst_errcnt", int'(O_ERR_CNT), 0);

        send("1a2F\r", 1'b1);
        idle(3);
        chk("t1_tokens", got_bin.size(), 1);
        chk("t1_bin",    bin_at(0), 'h1A2F);
        chk("t1_digits", dig_at(0), 4);
        chk("t1_err",    err_cycles, 0);
        clear_log();

        send("7 ,\n", 1'b1);
        idle(3);
        chk("t2_tokens", got_bin.size(), 1);
        chk("t2_bin",    bin_at(0), 'h0007);
        chk("t2_digits", dig_at(0), 1);
        clear_log();

        send("12345\nab\n", 1'b1);
        idle(3);
        chk("t3_err",    err_cycles, 1);
        chk("t3_errcnt", int'(O_ERR_CNT), 1);
        chk("t3_tokens", got_bin.size(), 1);
        chk("t3_bin",    bin_at(0), 'h00AB);
        chk("t3_digits", dig_at(0), 2);
        clear_log();

        send("1g2\nFF\n", 1'b1);
        idle(3);
        chk("t4_err",    err_cycles, 1);
        chk("t4_errcnt", int'(O_ERR_CNT), 2);
        chk("t4_tokens", got_bin.size(), 1);
        chk("t4_bin",    bin_at(0), 'h00FF);
        clear_log();

        send("beef\n", 1'b0);
        repeat (6) cyc(1'b1, "1", 1'b0);
        cyc(1'b1, "1", 1'b1);
        cyc(1'b1, "1", 1'b1);
        send("2\n", 1'b1);
        idle(3);
        chk("t5_tokens", got_bin.size(), 2);
        chk("t5_bin0",   bin_at(0), 'hBEEF);
        chk("t5_dig0",   dig_at(0), 4);
        chk("t5_bin1",   bin_at(1), 'h0012);
        chk("t5_hold",   hold_cycles, 8);
        clear_log();

        send("ab", 1'b1);
        do_reset(2);
        send("c\n", 1'b1);
        idle(3);
        chk("t6_tokens", got_bin.size(), 1);
        chk("t6_bin",    bin_at(0), 'h000C);
        chk("t6_errcnt", int'(O_ERR_CNT), 0);
        clear_log();

        repeat (300) cyc(1'b1, "x", 1'b1);
        send("\n", 1'b1);
        idle(2);
        chk("t7_errcyc", err_cycles, 300);
        chk("t7_errcnt", int'(O_ERR_CNT), 255);
        chk("t7_tokens", got_bin.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ascii2bin_parser.md
# ascii2bin_parser

Parses a byte stream of ASCII hexadecimal characters into 16-bit binary values. It sits on the receive path of the USB/serial command interface and turns typed tokens such as "1a2F\r" into binary words for downstream register logic. A token is 1–4 hex digits terminated by a delimiter. The block applies valid/ready flow control on both sides, rejects malformed or overlong tokens, and counts errors.

## Interface
- No parameters.
- I_CLK  in  1  system clock.
- I_RSTF  in  1  reset, asynchronous, active-low.
- I_CHAR  in  8  ASCII character.
- I_CHAR_VALID  in  1  I_CHAR is valid.
- O_CHAR_READY  out  1  parser accepts a character this cycle.
- O_BIN  out  16  parsed value.
- O_BIN_VALID  out  1  O_BIN holds a completed token.
- I_BIN_READY  in  1  consumer accepts O_BIN.
- O_DIGITS  out  3  digit count of the current token (0–4).
- O_ERR  out  1  one-cycle error pulse.
- O_ERR_CNT  out  8  saturating error counter.

## Operation
- Character classes:
  - Hex digit: 0x30–0x39 ('0'–'9') maps to 0–9. 0x61–0x66 ('a'–'f') and 0x41–0x46 ('A'–'F') map to 10–15.
  - Delimiter: 0x0D, 0x0A, 0x20, 0x2C.
  - Invalid: everything else.
- Accept event: I_CHAR_VALID & O_CHAR_READY at a rising edge.
- O_CHAR_READY = 1 in IDLE, ACCUM and DISCARD; 0 in HOLD. It is combinational from state only.
- State machine:
  - IDLE:
    - Digit → acc=digit, cnt=1, go to ACCUM.
    - Delimiter → ignored, stay in IDLE. Empty tokens produce no output.
    - Invalid → error, go to DISCARD.
  - ACCUM:
    - Digit with cnt<4 → acc={acc[11:0],digit}, cnt+1.
    - Digit with cnt==4 → overflow error, go to DISCARD.
    - Delimiter → O_BIN=acc, go to HOLD.
    - Invalid → error, go to DISCARD.
  - HOLD:
    - O_BIN_VALID=1 and O_BIN is stable.
    - I_BIN_READY=1 → go to IDLE, cnt=0.
  - DISCARD:
    - All characters are dropped. Delimiter → IDLE. No output is produced for the bad token.
- Value is zero-extended: "7" gives 0x0007.
- O_BIN updates only on entry to HOLD and holds its last value otherwise.
- O_DIGITS = cnt:
  - Increments per accepted digit in ACCUM.
  - Holds the token length during HOLD.
  - Is 0 in IDLE and DISCARD.
- Error event (invalid character, or 5th digit):
  - O_ERR=1 for exactly one cycle.
  - O_ERR_CNT increments and saturates at 255.
  - cnt clears to 0.

## Timing
- Reset values: state IDLE, O_BIN=0x0000, O_BIN_VALID=0, O_ERR=0, O_ERR_CNT=0, O_DIGITS=0, O_CHAR_READY=1.
- Reset is asynchronous and takes effect mid-token or in HOLD. A partial token or pending value is lost and no O_BIN_VALID is issued.
- Latency:
  - Delimiter accepted in cycle N → O_BIN_VALID=1 from cycle N+1.
  - Offending character accepted in cycle N → O_ERR=1 in cycle N+1 only. O_ERR_CNT is updated in cycle N+1.
- Handshake:
  - O_BIN_VALID stays high, with O_BIN unchanged, until the cycle in which I_BIN_READY=1. It drops in the following cycle.
  - Minimum one HOLD cycle per token. With I_BIN_READY tied high, throughput is one token per (digits+2) cycles.
  - O_CHAR_READY=0 in HOLD back-pressures the source. I_CHAR is not sampled. The next character is accepted no earlier than the cycle after HOLD exits.
- Throughput: one character per cycle outside HOLD, with no bubbles between digits.
- I_CHAR_VALID=0 cycles inside a token do not alter state.

## Test plan
- "1a2F\r", one char per cycle, I_BIN_READY=1 → single O_BIN_VALID pulse. O_BIN=0x1A2F, O_DIGITS=4 during HOLD, O_ERR never asserted.
- "7 ,\n" → O_BIN=0x0007 once. The second and third delimiters produce no output.
- "12345\nab\n" → one O_ERR pulse the cycle after '5', O_ERR_CNT=1, no output for the first token. Then O_BIN=0x00AB, O_DIGITS=2.
- "1g2\n" → O_ERR after 'g', no O_BIN_VALID. The following "FF\n" yields 0x00FF.
- Backpressure: "beef\n" then "12\n" with I_BIN_READY=0 for 6 cycles → O_BIN_VALID held at 0xBEEF and O_CHAR_READY=0 for those cycles. The '1' is not consumed until after release. Then 0x0012.
- Reset pulse after "ab" (mid-token), then "c\n" → outputs at reset values during reset. The next token gives 0x000C, with no stale 0x00AB output. Also: 300 consecutive 'x' characters → O_ERR_CNT saturates at 255.
